// File: rtl/trigger_capture.sv
// Triggered frame capture: samples circulate through a ring RAM until a level
// crossing (or force) is seen, then the frame is streamed as sync byte + samples.
module trigger_capture #(
    parameter int         pDepth   = 256,
    parameter int         pAddrW   = 8,
    parameter int         pPreTrig = 32,
    parameter logic [7:0] pSync    = 8'hA5
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iData,
    input  logic       iData_Valid,
    input  logic [7:0] iLevel,
    input  logic       iRising,
    input  logic       iArm,
    input  logic       iAuto,
    input  logic       iForce,
    output logic       oTx_DV,
    output logic [7:0] oTx_Byte,
    input  logic       iTx_Active,
    input  logic       iTx_Done,
    output logic [2:0] oState,
    output logic       oTriggered
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_HDR  = 3'd4,
        S_DATA = 3'd5
    } state_t;

    localparam logic [pAddrW-1:0] cPreOff   = pAddrW'(pPreTrig);
    localparam logic [pAddrW:0]   cPreLast  = (pAddrW+1)'(pPreTrig - 1);
    localparam logic [pAddrW:0]   cPostLen  = (pAddrW+1)'(pDepth - pPreTrig);
    localparam logic [pAddrW:0]   cFrameLen = (pAddrW+1)'(pDepth);

    logic [7:0]        r_ram [0:pDepth-1];
    logic [7:0]        r_rd_data;

    state_t            r_state;
    state_t            w_next;
    logic [pAddrW-1:0] r_wp;
    logic [pAddrW-1:0] r_start;
    logic [pAddrW-1:0] r_rd_addr;
    logic [pAddrW:0]   r_pre_cnt;
    logic [pAddrW:0]   r_post_cnt;
    logic [pAddrW:0]   r_byte_cnt;
    logic [7:0]        r_prev;
    logic              r_have_prev;
    logic              r_busy;
    logic              r_hdr_sent;
    logic              r_rd_rdy;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;
    logic              r_triggered;

    logic              w_edge;
    logic              w_wr_en;
    logic              w_arm;
    logic              w_trigger;
    logic              w_send_hdr;
    logic              w_send_data;
    logic              w_go_data;
    logic              w_done;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte handshake: a strobe only goes out when no byte is in flight
    // (busy low) and the transmitter reports idle; busy drops on iTx_Done.
    always_comb begin
        w_next      = r_state;
        w_wr_en     = 1'b0;
        w_arm       = 1'b0;
        w_trigger   = 1'b0;
        w_send_hdr  = 1'b0;
        w_send_data = 1'b0;
        w_go_data   = 1'b0;
        w_done      = 1'b0;
        w_edge      = r_have_prev &&
                      (iRising ? ((r_prev < iLevel) && (iData >= iLevel))
                               : ((r_prev > iLevel) && (iData <= iLevel)));
        case (r_state)
            S_IDLE: begin
                if (iArm) begin
                    w_arm  = 1'b1;
                    w_next = S_PRE;
                end
            end
            S_PRE: begin
                if (iData_Valid) begin
                    w_wr_en = 1'b1;
                    if (r_pre_cnt == cPreLast) w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iData_Valid) begin
                    w_wr_en = 1'b1;
                    if (w_edge || iForce) begin
                        w_trigger = 1'b1;
                        w_next    = (pDepth - pPreTrig == 1) ? S_HDR : S_POST;
                    end
                end
            end
            S_POST: begin
                if (iData_Valid) begin
                    w_wr_en = 1'b1;
                    if (r_post_cnt + 1'b1 == cPostLen) w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (!r_hdr_sent) begin
                    if (!r_busy && !iTx_Active) w_send_hdr = 1'b1;
                end else if (!r_busy) begin
                    w_go_data = 1'b1;
                    w_next    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_byte_cnt == cFrameLen) begin
                    if (!r_busy) begin
                        w_done = 1'b1;
                        w_next = iAuto ? S_PRE : S_IDLE;
                    end
                end else if (r_rd_rdy && !r_busy && !iTx_Active) begin
                    w_send_data = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wp        <= '0;
            r_start     <= '0;
            r_rd_addr   <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_busy      <= 1'b0;
            r_hdr_sent  <= 1'b0;
            r_rd_rdy    <= 1'b0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_tx_dv <= w_send_hdr | w_send_data;

            if (w_arm || w_done) begin
                r_pre_cnt   <= '0;
                r_post_cnt  <= '0;
                r_have_prev <= 1'b0;
                r_hdr_sent  <= 1'b0;
            end

            if (w_wr_en) begin
                r_wp        <= r_wp + 1'b1;
                r_prev      <= iData;
                r_have_prev <= 1'b1;
                if (r_state == S_PRE)  r_pre_cnt  <= r_pre_cnt + 1'b1;
                if (r_state == S_POST) r_post_cnt <= r_post_cnt + 1'b1;
            end

            if (w_trigger) begin
                r_start     <= r_wp - cPreOff;
                r_post_cnt  <= (pAddrW+1)'(1);
                r_triggered <= 1'b1;
                r_hdr_sent  <= 1'b0;
            end

            if (w_send_hdr || w_send_data) begin
                r_busy <= 1'b1;
            end else if (iTx_Done) begin
                r_busy <= 1'b0;
            end

            if (w_send_hdr) begin
                r_tx_byte  <= pSync;
                r_hdr_sent <= 1'b1;
            end

            // r_rd_rdy marks that r_rd_data reflects the current r_rd_addr.
            if (w_go_data) begin
                r_rd_addr  <= r_start;
                r_byte_cnt <= '0;
                r_rd_rdy   <= 1'b0;
            end else if (w_send_data) begin
                r_tx_byte  <= r_rd_data;
                r_rd_addr  <= r_rd_addr + 1'b1;
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_rd_rdy   <= 1'b0;
            end else if (r_state == S_DATA) begin
                r_rd_rdy   <= 1'b1;
            end

            if (w_done) r_triggered <= 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (w_wr_en) r_ram[r_wp] <= iData;
        r_rd_data <= r_ram[r_rd_addr];
    end

    assign oTx_DV     = r_tx_dv;
    assign oTx_Byte   = r_tx_byte;
    assign oState     = r_state;
    assign oTriggered = r_triggered;

endmodule
